img_packet_gen: RTL
===================

Name: img_packet_gen

Overview:
- Parametrised frame packetiser between the image pre-processing stream and the DDR write FIFO.
- Packs one frame of DATA_W-bit words into the FIFO, then appends a fixed trailer of one line (LINE_NUM words): a parity block, a frame-info block and zero padding.
- Adds over the previous generation: configurable data width, dropped-word accounting, truncation of frames cut short by a new frame_start, and a busy indication.

Parameters:
- DATA_W, 32, stream/FIFO word width; multiple of 32, max 128.
- PIX_SIZE, 8, bits per pixel; must divide DATA_W.
- LINE_SIZE, 1024, pixels per line; LINE_NUM = LINE_SIZE*PIX_SIZE/DATA_W, must be >= 8.
- IMAGE_SIZE, 1048576, pixels per frame; WR_NUM = IMAGE_SIZE*PIX_SIZE/DATA_W, must be >= 1.
- PKT_MODE, "2D", "2D" or "3D"; sets mode byte and write-enable qualification.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  DATA_W  pixel stream word.
- data_in_valid  in  1  word qualifier; the source cannot stall.
- frame_start  in  1  level; rising edge marks frame start.
- frame_type_i  in  2  frame type, sampled at the frame_start rise.
- wr2ddr_en  in  1  global store enable.
- fifo_full  in  1  FIFO full.
- fifo_wrdata  out  DATA_W  FIFO write data.
- fifo_wren  out  1  FIFO write strobe.
- fifo_overflow  out  1  sticky flag: a word was dropped.
- frame_store  out  1  one-cycle pulse: a stored frame has completed.
- frame_type_o  out  2  latched frame type.
- frame_trunc  out  1  one-cycle pulse: the current frame was aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Inputs (data_in, data_in_valid, frame_start, frame_type_i, wr2ddr_en) are registered once; rise = q & ~qq. Data-in to fifo_wren latency is 2 clk.
- store_en latch:
  - cleared while registered wr2ddr_en = 0;
  - set on rise when wr2ddr_en = 1, and additionally, in "2D" mode only, frame_type = 0.
- Every FIFO write requires store_en = 1; with store_en = 0 the state machine runs but fifo_wren stays 0.
- States:
  - IDLE: on rise, latch type, clear parity, clear word and drop counters, go to WR_DATA.
  - WR_DATA: each valid word increments word_cnt. If fifo_full, the word is dropped: fifo_overflow set (sticky until reset), drop_cnt+1 (saturating 16b). Leave when word_cnt reaches WR_NUM. A rise in WR_DATA aborts: pulse frame_trunc, set trunc flag, go to PARITY. That rise does not start a new frame.
  - PARITY: 4 words. Word 0 = XOR of all words accepted in WR_DATA; words 1..3 = 0.
  - FRAME_INFO: 4 words.
    - dw0 = {14'b0, ovf_in_frame, trunc, 6'b0, type, mode}; mode = 0 for "2D", 1 for "3D".
    - dw1 = {drop_cnt, word_cnt[15:0]}.
    - dw2 = 0.
    - dw3 = frame_cnt.
    - Each dword is zero-extended to DATA_W.
  - FLUSH: zero words until trailer total = LINE_NUM. With LINE_NUM = 8, FLUSH lasts 0 words.
  - DONE: 1 cycle. If store_en, pulse frame_store and increment frame_cnt (32b, wraps). Then go to IDLE.
- Trailer states advance only on cycles with fifo_full = 0; the trailer counter holds while full.
- Rises during trailer states and DONE are ignored.
- data_in_valid outside WR_DATA is ignored.
- Reset mid-frame: returns to IDLE and resets frame_cnt and fifo_overflow.

Optional Feature:
- IMG_PKT_TIMESTAMP_EN defined: a 32b free-running cycle counter, reset to 0, is captured at the frame_start rise and placed in dw2.
- Undefined: dw2 = 0 and no counter is built.

Decomposition:
- Package img_pkt_pkg holds:
  - state encoding;
  - PARITY_WORDS = 4, INFO_WORDS = 4;
  - bit positions of the dw0 fields;
  - mode codes.
- One sub-module, img_pkt_parity: a DATA_W XOR accumulator with clear and enable.

Test Plan:
(DATA_W=32, PIX_SIZE=8, LINE_SIZE=64 → LINE_NUM=16, IMAGE_SIZE=128 → WR_NUM=32, "2D")
- Type 0, wr2ddr_en=1, 32 words 0..31, never full → 48 writes total:
  - words 0..31;
  - parity 0x00000000, then 3 zeros;
  - dw0 = 0x00000000, dw1 = 0x00000020, dw2 = 0, dw3 = 0;
  - 8 zero pad words;
  - frame_store pulses once.
- Same frame with type 2 in "2D" → no fifo_wren at all; FSM still runs; frame_cnt stays 0.
- fifo_full held for 3 cycles while valid in WR_DATA → 3 words dropped:
  - fifo_overflow stays 1;
  - dw1 = 0x00030020;
  - dw0 bit17 = 1.
- fifo_full asserted for 5 cycles during FRAME_INFO → trailer stalls; no info word is lost or duplicated; total writes still 48.
- Second rise after 10 words → frame_trunc pulses:
  - trailer follows immediately;
  - dw0 = 0x00010000, dw1 = 0x0000000A;
  - FSM returns to IDLE and waits for the next rise.
- Second full frame → dw3 = 1. With IMG_PKT_TIMESTAMP_EN, dw2 equals the cycle count captured at the rise.

Source files
------------

// File: rtl/img_pkt_pkg.sv
// rtl/img_pkt_pkg.sv - shared state codes, trailer sizes and frame-info field positions for img_packet_gen
package img_pkt_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_DATA    = 3'd1;
  localparam logic [2:0] ST_PARITY     = 3'd2;
  localparam logic [2:0] ST_FRAME_INFO = 3'd3;
  localparam logic [2:0] ST_FLUSH      = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  localparam int PARITY_WORDS = 4;
  localparam int INFO_WORDS   = 4;

  localparam int DW0_MODE_LSB  = 0;
  localparam int DW0_TYPE_LSB  = 8;
  localparam int DW0_TRUNC_BIT = 16;
  localparam int DW0_OVF_BIT   = 17;

  localparam logic [7:0] MODE_2D = 8'd0;
  localparam logic [7:0] MODE_3D = 8'd1;

endpackage

// File: rtl/img_pkt_parity.sv
// rtl/img_pkt_parity.sv - DATA_W-wide XOR accumulator with synchronous clear and enable
module img_pkt_parity #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] parity
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign parity = acc_q;

endmodule

// File: rtl/img_packet_gen.sv
// rtl/img_packet_gen.sv - frame packetiser: data words, then a one-line trailer (parity, frame info, padding)
// IMG_PKT_TIMESTAMP_EN puts the frame-start cycle count into info dword 2.
module img_packet_gen
  import img_pkt_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    PIX_SIZE   = 8,
  parameter int    LINE_SIZE  = 1024,
  parameter int    IMAGE_SIZE = 1048576,
  parameter string PKT_MODE   = "2D"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              frame_start,
  input  logic [1:0]        frame_type_i,
  input  logic              wr2ddr_en,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_wrdata,
  output logic              fifo_wren,
  output logic              fifo_overflow,
  output logic              frame_store,
  output logic [1:0]        frame_type_o,
  output logic              frame_trunc,
  output logic              busy
);

  localparam logic [31:0] LINE_NUM  = 32'(LINE_SIZE * PIX_SIZE / DATA_W);
  localparam logic [31:0] WR_NUM    = 32'(IMAGE_SIZE * PIX_SIZE / DATA_W);
  localparam logic [31:0] PAR_LAST  = 32'(PARITY_WORDS - 1);
  localparam logic [31:0] INFO_LAST = 32'(PARITY_WORDS + INFO_WORDS - 1);
  localparam logic        IS_3D     = (PKT_MODE == "3D");
  localparam logic [7:0]  MODE_CODE = IS_3D ? MODE_3D : MODE_2D;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, fs_q, fs_qq, wr_en_q;
  logic [1:0]        type_in_q;

  logic [2:0]        state_q, state_d;
  logic [31:0]       trl_cnt_q, trl_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              store_en_q, store_en_d;
  logic              trunc_q, trunc_d;
  logic              ovf_frame_q, ovf_frame_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        type_q, type_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              wren_q, wren_d;
  logic              store_pls_q, store_pls_d;
  logic              trunc_pls_q, trunc_pls_d;

  logic              rise, par_clr, par_en;
  logic [DATA_W-1:0] parity;
  logic [DATA_W-1:0] trailer_word;
  logic [31:0]       info_dw;
  logic [31:0]       ts_dw;

  assign rise = fs_q & ~fs_qq;

  img_pkt_parity #(.DATA_W(DATA_W)) u_parity (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (par_clr),
    .en     (par_en),
    .data   (data_q),
    .parity (parity)
  );

`ifdef IMG_PKT_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d, ts_cap_q, ts_cap_d;

  assign ts_cnt_d = ts_cnt_q + 32'd1;
  assign ts_cap_d = (state_q == ST_IDLE && rise) ? ts_cnt_q : ts_cap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_cap_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_cap_q <= ts_cap_d;
    end
  end

  assign ts_dw = ts_cap_q;
`else
  assign ts_dw = 32'd0;
`endif

  // Info dword index equals trl_cnt[1:0] because the info block sits at trailer words 4..7.
  always_comb begin
    info_dw = '0;
    case (trl_cnt_q[1:0])
      2'd0: begin
        info_dw[DW0_OVF_BIT]         = ovf_frame_q;
        info_dw[DW0_TRUNC_BIT]       = trunc_q;
        info_dw[DW0_TYPE_LSB +: 2]   = type_q;
        info_dw[DW0_MODE_LSB +: 8]   = MODE_CODE;
      end
      2'd1:    info_dw = {drop_cnt_q, word_cnt_q[15:0]};
      2'd2:    info_dw = ts_dw;
      default: info_dw = frame_cnt_q;
    endcase
    trailer_word = '0;
    if (state_q == ST_PARITY && trl_cnt_q == 32'd0) begin
      trailer_word = parity;
    end else if (state_q == ST_FRAME_INFO) begin
      trailer_word = DATA_W'(info_dw);
    end
  end

  always_comb begin
    state_d     = state_q;
    trl_cnt_d   = trl_cnt_q;
    word_cnt_d  = word_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    store_en_d  = store_en_q;
    trunc_d     = trunc_q;
    ovf_frame_d = ovf_frame_q;
    ovf_d       = ovf_q;
    type_d      = type_q;
    wrdata_d    = '0;
    wren_d      = 1'b0;
    store_pls_d = 1'b0;
    trunc_pls_d = 1'b0;
    par_clr     = 1'b0;
    par_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_WR_DATA;
          type_d      = type_in_q;
          par_clr     = 1'b1;
          word_cnt_d  = '0;
          drop_cnt_d  = '0;
          trl_cnt_d   = '0;
          trunc_d     = 1'b0;
          ovf_frame_d = 1'b0;
          store_en_d  = wr_en_q & (IS_3D | (type_in_q == 2'd0));
        end
      end
      ST_WR_DATA: begin
        if (rise) begin
          trunc_pls_d = 1'b1;
          trunc_d     = 1'b1;
          state_d     = ST_PARITY;
        end else if (valid_q) begin
          word_cnt_d = word_cnt_q + 32'd1;
          if (fifo_full) begin
            ovf_d       = 1'b1;
            ovf_frame_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
          end else begin
            par_en   = 1'b1;
            wren_d   = store_en_q;
            wrdata_d = data_q;
          end
          if (word_cnt_d == WR_NUM) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY, ST_FRAME_INFO, ST_FLUSH: begin
        if (!fifo_full) begin
          wren_d    = store_en_q;
          wrdata_d  = trailer_word;
          trl_cnt_d = trl_cnt_q + 32'd1;
          if (trl_cnt_q == LINE_NUM - 32'd1) begin
            state_d = ST_DONE;
          end else if (trl_cnt_q == PAR_LAST) begin
            state_d = ST_FRAME_INFO;
          end else if (trl_cnt_q == INFO_LAST) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (store_en_q) begin
          store_pls_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!wr_en_q) begin
      store_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      fs_qq       <= 1'b0;
      wr_en_q     <= 1'b0;
      type_in_q   <= '0;
      state_q     <= ST_IDLE;
      trl_cnt_q   <= '0;
      word_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
      store_en_q  <= 1'b0;
      trunc_q     <= 1'b0;
      ovf_frame_q <= 1'b0;
      ovf_q       <= 1'b0;
      type_q      <= '0;
      wrdata_q    <= '0;
      wren_q      <= 1'b0;
      store_pls_q <= 1'b0;
      trunc_pls_q <= 1'b0;
    end else begin
      data_q      <= data_in;
      valid_q     <= data_in_valid;
      fs_q        <= frame_start;
      fs_qq       <= fs_q;
      wr_en_q     <= wr2ddr_en;
      type_in_q   <= frame_type_i;
      state_q     <= state_d;
      trl_cnt_q   <= trl_cnt_d;
      word_cnt_q  <= word_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      store_en_q  <= store_en_d;
      trunc_q     <= trunc_d;
      ovf_frame_q <= ovf_frame_d;
      ovf_q       <= ovf_d;
      type_q      <= type_d;
      wrdata_q    <= wrdata_d;
      wren_q      <= wren_d;
      store_pls_q <= store_pls_d;
      trunc_pls_q <= trunc_pls_d;
    end
  end

  assign fifo_wrdata   = wrdata_q;
  assign fifo_wren     = wren_q;
  assign fifo_overflow = ovf_q;
  assign frame_store   = store_pls_q;
  assign frame_type_o  = type_q;
  assign frame_trunc   = trunc_pls_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
